// File: rtl/sitcp_pkg.sv
// rtl/sitcp_pkg.sv - shared widths, timebase moduli and counter sizing for the SiTCP front end
package sitcp_pkg;

  localparam int IP_W      = 32;
  localparam int PORT_W    = 16;
  localparam int US_PER_MS = 1000;
  localparam int MS_PER_S  = 1000;
  localparam int S_PER_MIN = 60;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sitcp_tick_div.sv
// rtl/sitcp_tick_div.sv - modulus-N enabled counter with combinational wrap and registered tick
module sitcp_tick_div
  import sitcp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam int W = cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // wrap feeds the next stage's enable so the whole cascade registers its ticks on one edge
  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/sitcp_timebase_cfg.sv
// rtl/sitcp_timebase_cfg.sv - us/ms/s/min tick strobes plus IP/port selection and apply logic
// SITCP_CFG_SETTLE_EN: when defined, a candidate must stay stable for SETTLE_US ticks before it is applied.
module sitcp_timebase_cfg
  import sitcp_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 133,
  parameter int NUM_PORT     = 2,
  parameter int SETTLE_US    = 100
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FORCE_DEFAULTn,
  input  logic [IP_W-1:0]            EXT_IP_ADDR,
  input  logic [IP_W-1:0]            DEFAULT_IP_ADDR,
  input  logic [PORT_W*NUM_PORT-1:0] EXT_PORT,
  input  logic [PORT_W*NUM_PORT-1:0] DEFAULT_PORT,
  output logic [IP_W-1:0]            MY_IP_ADDR,
  output logic [PORT_W*NUM_PORT-1:0] MY_PORT,
  output logic                       CFG_VALID,
  output logic                       CFG_CHANGE,
  output logic                       TIM_1US,
  output logic                       TIM_1MS,
  output logic                       TIM_1S,
  output logic                       TIM_1M
);

  localparam int PW = PORT_W * NUM_PORT;

  logic us_wrap;
  logic ms_wrap;
  logic s_wrap;
  logic min_wrap;

  sitcp_tick_div #(.N(CLK_FREQ_MHZ)) u_us_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (1'b1),
    .wrap (us_wrap),
    .tick (TIM_1US)
  );

  sitcp_tick_div #(.N(US_PER_MS)) u_ms_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (us_wrap),
    .wrap (ms_wrap),
    .tick (TIM_1MS)
  );

  sitcp_tick_div #(.N(MS_PER_S)) u_s_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (ms_wrap),
    .wrap (s_wrap),
    .tick (TIM_1S)
  );

  sitcp_tick_div #(.N(S_PER_MIN)) u_min_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (s_wrap),
    .wrap (min_wrap),
    .tick (TIM_1M)
  );

  logic [IP_W-1:0] cand_ip;
  logic [PW-1:0]   cand_port;

  // A zero external field means "not set on the board", so it falls back per field.
  always_comb begin
    cand_ip   = (!FORCE_DEFAULTn || EXT_IP_ADDR == '0) ? DEFAULT_IP_ADDR : EXT_IP_ADDR;
    cand_port = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      cand_port[PORT_W*k +: PORT_W] =
        (!FORCE_DEFAULTn || EXT_PORT[PORT_W*k +: PORT_W] == '0) ?
        DEFAULT_PORT[PORT_W*k +: PORT_W] : EXT_PORT[PORT_W*k +: PORT_W];
    end
  end

  logic            apply;
  logic [IP_W-1:0] apply_ip;
  logic [PW-1:0]   apply_port;

`ifdef SITCP_CFG_SETTLE_EN
  localparam logic [15:0] SETTLE_CNT = 16'(SETTLE_US);

  logic [IP_W-1:0] pend_ip;
  logic [PW-1:0]   pend_port;
  logic [15:0]     scnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_ip   <= '0;
      pend_port <= '0;
      scnt      <= '0;
    end else if ({cand_port, cand_ip} != {pend_port, pend_ip}) begin
      pend_ip   <= cand_ip;
      pend_port <= cand_port;
      scnt      <= '0;
    end else if (TIM_1US && scnt != 16'hFFFF) begin
      scnt <= scnt + 16'd1;
    end
  end

  assign apply      = (scnt == SETTLE_CNT) &&
                      (({pend_port, pend_ip} != {MY_PORT, MY_IP_ADDR}) || !CFG_VALID);
  assign apply_ip   = pend_ip;
  assign apply_port = pend_port;
`else
  assign apply      = ({cand_port, cand_ip} != {MY_PORT, MY_IP_ADDR}) || !CFG_VALID;
  assign apply_ip   = cand_ip;
  assign apply_port = cand_port;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      MY_IP_ADDR <= '0;
      MY_PORT    <= '0;
      CFG_VALID  <= 1'b0;
      CFG_CHANGE <= 1'b0;
    end else begin
      CFG_CHANGE <= apply;
      if (apply) begin
        MY_IP_ADDR <= apply_ip;
        MY_PORT    <= apply_port;
        CFG_VALID  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sitcp_timebase_cfg.sv
// tb/tb_sitcp_timebase_cfg.sv - randomized self-checking bench against a tick-count reference model
module tb_sitcp_timebase_cfg;

  localparam int N  = 4;
  localparam int NP = 2;
  localparam int S  = 3;
  localparam int PW = 16 * NP;

  typedef logic [32+PW-1:0] cfg_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FORCE_DEFAULTn = 1'b1;
  logic [31:0]   EXT_IP_ADDR = '0;
  logic [31:0]   DEFAULT_IP_ADDR = '0;
  logic [PW-1:0] EXT_PORT = '0;
  logic [PW-1:0] DEFAULT_PORT = '0;
  logic [31:0]   MY_IP_ADDR;
  logic [PW-1:0] MY_PORT;
  logic          CFG_VALID;
  logic          CFG_CHANGE;
  logic          TIM_1US;
  logic          TIM_1MS;
  logic          TIM_1S;
  logic          TIM_1M;

  sitcp_timebase_cfg #(
    .CLK_FREQ_MHZ (N),
    .NUM_PORT     (NP),
    .SETTLE_US    (S)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .FORCE_DEFAULTn  (FORCE_DEFAULTn),
    .EXT_IP_ADDR     (EXT_IP_ADDR),
    .DEFAULT_IP_ADDR (DEFAULT_IP_ADDR),
    .EXT_PORT        (EXT_PORT),
    .DEFAULT_PORT    (DEFAULT_PORT),
    .MY_IP_ADDR      (MY_IP_ADDR),
    .MY_PORT         (MY_PORT),
    .CFG_VALID       (CFG_VALID),
    .CFG_CHANGE      (CFG_CHANGE),
    .TIM_1US         (TIM_1US),
    .TIM_1MS         (TIM_1MS),
    .TIM_1S          (TIM_1S),
    .TIM_1M          (TIM_1M)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cycle index since reset, last candidate and the cycle it was first seen.
  cfg_t m_my;
  cfg_t m_pend;
  bit   m_valid;
  bit   m_change;
  int   m_load;
  int   k;
  int   pulses;

  function automatic logic [31:0] pick(input logic fn, input logic [31:0] e, input logic [31:0] d);
    return (!fn || e == 32'd0) ? d : e;
  endfunction

  function automatic cfg_t cand_of();
    cfg_t c;
    c[31:0] = pick(FORCE_DEFAULTn, EXT_IP_ADDR, DEFAULT_IP_ADDR);
    for (int f = 0; f < NP; f++) begin
      c[32+16*f +: 16] = 16'(pick(FORCE_DEFAULTn, 32'(EXT_PORT[16*f +: 16]),
                                  32'(DEFAULT_PORT[16*f +: 16])));
    end
    return c;
  endfunction

  // Number of 1 us strobes seen in cycles a..b (strobe cycles are positive multiples of N).
  function automatic int ticks_in(input int a, input int b);
    int lo;
    lo = (a < 1) ? 1 : a;
    if (b < lo) return 0;
    return b / N - (lo - 1) / N;
  endfunction

  task automatic step();
    cfg_t c;
    cfg_t nxt;
    bit   apply;
    c = cand_of();
    @(posedge CLK);
    if (RST) begin
      k = 0; m_my = '0; m_pend = '0; m_valid = 0; m_change = 0; m_load = 0;
    end else begin
      k++;
`ifdef SITCP_CFG_SETTLE_EN
      apply = (ticks_in(m_load, k - 2) == S) && (m_pend != m_my || !m_valid);
      nxt   = m_pend;
      if (c != m_pend) begin
        m_pend = c;
        m_load = k;
      end
`else
      apply = (c != m_my) || !m_valid;
      nxt   = c;
`endif
      m_change = apply;
      if (apply) begin
        m_my    = nxt;
        m_valid = 1;
      end
    end
    #1;
    check("tim_1us", TIM_1US, (k > 0) && (k % N == 0));
    check("tim_1ms", TIM_1MS, (k > 0) && (k % (1000 * N) == 0));
    check("tim_1s", TIM_1S, (k > 0) && (k % (1000000 * N) == 0));
    check("tim_1m", TIM_1M, (k > 0) && (k % (60000000 * N) == 0));
    check("cfg_valid", CFG_VALID, m_valid);
    check("cfg_change", CFG_CHANGE, m_change);
    check("my_ip", MY_IP_ADDR, m_my[31:0]);
    check("my_port", MY_PORT, m_my[32 +: PW]);
    if (CFG_CHANGE) pulses++;
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] saved_ip;
  int          restore_at;
  int          rst_at;
  int          r;
  int          idx;

  initial begin
    EXT_IP_ADDR     = 32'hC0A8000A;
    EXT_PORT        = {16'd4660, 16'd24};
    DEFAULT_IP_ADDR = 32'h0A000001;
    DEFAULT_PORT    = {16'd4660, 16'd80};
    @(negedge CLK);
    run(2);
    check("rst_valid", CFG_VALID, 1'b0);
    check("rst_ip", MY_IP_ADDR, 32'd0);
    check("rst_ticks", {TIM_1US, TIM_1MS, TIM_1S, TIM_1M}, 4'd0);

    RST = 1'b0;
    pulses = 0;
    run(40);
    check("first_apply_ip", MY_IP_ADDR, 32'hC0A8000A);
    check("first_apply_p0", MY_PORT[15:0], 16'd24);
    check("first_apply_pulses", pulses, 1);

    EXT_PORT[31:16] = 16'd0;
    run(40);
    check("zero_fallback_p1", MY_PORT[31:16], 16'd4660);
    check("zero_fallback_p0", MY_PORT[15:0], 16'd24);

    pulses   = 0;
    saved_ip = EXT_IP_ADDR;
    EXT_IP_ADDR = 32'h01020304;
    run(2 * N);
    EXT_IP_ADDR = saved_ip;
    run(40);
    check("glitch_ip", MY_IP_ADDR, 32'hC0A8000A);
`ifdef SITCP_CFG_SETTLE_EN
    check("glitch_pulses", pulses, 0);
`else
    check("glitch_pulses", pulses, 2);
`endif

    pulses = 0;
    FORCE_DEFAULTn = 1'b0;
    run(40);
    check("force_def_ip", MY_IP_ADDR, 32'h0A000001);
    check("force_def_port", MY_PORT, {16'd4660, 16'd80});
    check("force_def_pulses", pulses, 1);
    FORCE_DEFAULTn = 1'b1;

    EXT_IP_ADDR = 32'hC0A80063;
    run(5);
    RST = 1'b1;
    run(1);
    check("midrst_outs", {MY_IP_ADDR, MY_PORT}, 64'd0);
    check("midrst_flags", {CFG_VALID, CFG_CHANGE}, 2'd0);
    RST = 1'b0;
    pulses = 0;
    run(40);
    check("restart_pulses", pulses, 1);
    check("restart_ip", MY_IP_ADDR, 32'hC0A80063);

    restore_at = -1;
    rst_at     = $urandom_range(50, 400);
    saved_ip   = EXT_IP_ADDR;
    for (int cyc = 0; cyc < 9000; cyc++) begin
      r = $urandom_range(0, 49);
      case (r)
        0: begin
          saved_ip    = EXT_IP_ADDR;
          EXT_IP_ADDR = $urandom;
          restore_at  = cyc + $urandom_range(2, 3 * N * S);
        end
        1: begin
          idx = $urandom_range(0, NP - 1);
          EXT_PORT[16*idx +: 16] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
        end
        2: begin
          idx = $urandom_range(0, NP - 1);
          DEFAULT_PORT[16*idx +: 16] = 16'($urandom);
          DEFAULT_IP_ADDR = $urandom;
        end
        3: FORCE_DEFAULTn = ~FORCE_DEFAULTn;
        4: EXT_IP_ADDR = 32'd0;
        default: ;
      endcase
      if (cyc == restore_at) EXT_IP_ADDR = saved_ip;
      RST = (cyc == rst_at);
      step();
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sitcp_timebase_cfg.md
# sitcp_timebase_cfg

Parametrised timebase and network-configuration front end for the SiTCP core. It generates the 1 µs, 1 ms, 1 s and 1 min tick strobes for any integer system-clock frequency. It also resolves the IP address and NUM_PORT port numbers from external versus default values, applies a settle filter, and signals each accepted configuration change. It sits between board-level configuration inputs and the SiTCP library instance, replacing the fixed-width timer and combinational override muxes.

## Interface
- CLK_FREQ_MHZ, 133: system clock in MHz, range 2..1023; sets the µs prescaler modulus.
- NUM_PORT, 2: number of 16-bit port fields; port 0 is TCP main, port 1 is RBCP, and higher ports are user-defined.
- SETTLE_US, 100: number of consecutive µs ticks a new candidate configuration must stay stable before it is applied; range 1..65535.
- CLK  in  1  system clock; the only clock in the block.
- RST  in  1  reset, synchronous and active-high.
- FORCE_DEFAULTn  in  1  low selects defaults for every field.
- EXT_IP_ADDR  in  32  external IP address.
- DEFAULT_IP_ADDR  in  32  default IP address (from SiTCP).
- EXT_PORT  in  16*NUM_PORT  external ports; field k is bits [16k+15:16k].
- DEFAULT_PORT  in  16*NUM_PORT  default ports, same packing as EXT_PORT.
- MY_IP_ADDR  out  32  applied IP address.
- MY_PORT  out  16*NUM_PORT  applied ports, same packing.
- CFG_VALID  out  1  high once the first configuration has been applied.
- CFG_CHANGE  out  1  one-cycle pulse on every apply.
- TIM_1US, TIM_1MS, TIM_1S, TIM_1M  out  1 each  one-cycle tick strobes.

## Operation
- Prescaler: counter over 0..CLK_FREQ_MHZ-1. The wrap cycle registers TIM_1US high for the next cycle.
- Cascade:
  - ms counter 0..999 advances on each µs tick.
  - s counter 0..999 advances on each ms wrap.
  - min counter 0..59 advances on each s wrap.
  - Each stage's strobe is registered from its wrap, so TIM_1MS, TIM_1S and TIM_1M are coincident with the TIM_1US that completes them.
- Candidate selection, per field: if ~FORCE_DEFAULTn, or the EXT field equals 0, use DEFAULT; otherwise use EXT. Selection is evaluated independently per field.
- Settle filter: a register PEND holds the last candidate, and a counter SCNT is 16 bits, saturating.
  - If candidate != PEND: load PEND with the candidate and clear SCNT. This has priority over a simultaneous µs tick.
  - Else, on each µs tick: SCNT++.
  - If SCNT == SETTLE_US and (PEND != MY_* or !CFG_VALID): on the next edge, MY_* <= PEND, CFG_VALID <= 1, and CFG_CHANGE pulses for 1 cycle.
  - Re-applying an identical value never pulses CFG_CHANGE.
- Reset values: all counters = 0; PEND, MY_IP_ADDR, MY_PORT = 0; CFG_VALID = 0; CFG_CHANGE = 0; all TIM_* = 0.
- Reset mid-operation: state returns to reset values in the same edge, and any pending apply is discarded.

## Timing
- Counting the first edge with RST low as cycle 1:
  - TIM_1US is first high in cycle CLK_FREQ_MHZ, then every CLK_FREQ_MHZ cycles.
  - TIM_1MS is first high in cycle 1000*CLK_FREQ_MHZ.
  - TIM_1S is first high in cycle 1e6*CLK_FREQ_MHZ.
  - TIM_1M is first high in cycle 6e7*CLK_FREQ_MHZ.
- All strobes are exactly 1 cycle wide, with no jitter.
- Apply latency from a candidate change: between SETTLE_US and SETTLE_US+1 µs, plus 2 cycles.
- MY_* is stable except on the edge that asserts CFG_CHANGE.
- Widths:
  - Prescaler width is $clog2(CLK_FREQ_MHZ).
  - ms and s counters are 10 bits.
  - min counter is 6 bits.

## Configuration
- Macro SITCP_CFG_SETTLE_EN.
  - Defined: the settle filter operates as described above.
  - Undefined: PEND and SCNT are removed. A changed candidate is applied on the next edge (1-cycle latency), and CFG_CHANGE and CFG_VALID follow the same rules. SETTLE_US is ignored.

## Structure
- Package sitcp_pkg holds:
  - IP_W = 32 and PORT_W = 16.
  - US_PER_MS = 1000, MS_PER_S = 1000 and S_PER_MIN = 60.
  - The width function for counter sizing.
- Sub-module sitcp_tick_div: a modulus-N counter with an enable input and a registered wrap strobe. It is instantiated 4 times as the prescaler, ms, s and min stages.
- The top level holds the selection, settle filter and output registers.

## Test plan
- Ticks: CLK_FREQ_MHZ=4, release RST -> TIM_1US high in cycles 4, 8, 12, …; TIM_1MS first high in cycle 4000, coincident with TIM_1US; no other strobes before then.
- First apply: SETTLE_US=3, FORCE_DEFAULTn=1, EXT_IP_ADDR=0xC0A8000A, EXT_PORT={16'd4660, 16'd24} -> CFG_VALID rises and CFG_CHANGE pulses once, about 3 µs after reset, with MY_IP_ADDR=0xC0A8000A and MY_PORT[15:0]=24.
- Zero fallback: EXT_PORT[31:16]=0 with DEFAULT_PORT[31:16]=4660 -> MY_PORT[31:16]=4660 while the other fields stay EXT.
- Glitch rejection: toggle EXT_IP_ADDR for 2 µs and then restore it -> no CFG_CHANGE, MY_IP_ADDR unchanged.
- Force default: drop FORCE_DEFAULTn -> all fields take DEFAULT after the settle time, with exactly 1 CFG_CHANGE pulse.
- Reset during settle: assert RST for 1 cycle mid-settle -> all outputs 0 on the next cycle, and the first-apply sequence restarts.
